tdc_tap_decoder: RTL
====================

// Module: tdc_tap_decoder
// PURPOSE
// - Consumer end of the carry-chain delay line. The delay line emits an N-tap thermometer vector.
// - This block synchronises that vector and detects each new hit edge.
// - It encodes the edge position into a fine code, pairs it with a free-running coarse timestamp,
//   and buffers results for a valid/ready downstream.
// - Sits between the tapped-delay-line primitive and the measurement/readout logic.
// PARAMETERS
// - N        128  number of delay-line taps (>=4)
// - FINE_W   8    fine code width; must satisfy 2**FINE_W > N
// - COARSE_W 16   coarse counter width
// PORTS
// - clk        in   1         sample clock; same clock that latches the delay line
// - rst        in   1         asynchronous, active-high reset
// - taps       in   N         raw delay-line taps, asynchronous to clk; taps[0] nearest the input
// - out_valid  out  1         result available
// - out_ready  in   1         downstream accepts result when out_valid && out_ready
// - out_fine   out  FINE_W    leading-ones count of the captured vector, 1..N
// - out_coarse out  COARSE_W  coarse count at the cycle the hit was captured
// - out_sat    out  1         hit ran off the end of the chain (fine == N)
// - overflow   out  1         sticky: a hit was dropped because the buffer was full
// - clr_ovf    in   1         synchronous clear of overflow (one-cycle pulse)
// BEHAVIOUR
// - Reset (async, rst=1): all pipeline regs, coarse counter, buffer pointers, overflow = 0.
//   - out_valid, out_fine, out_coarse, out_sat are 0 during reset and on the first edge after release.
//   - Asserting rst mid-operation discards all in-flight and buffered results.
// - Coarse counter: increments every clk and wraps 2**COARSE_W-1 -> 0.
//   - A snapshot is taken alongside the S1 capture so the timestamp refers to the S1 cycle.
// - Pipeline, one stage per clk:
//   - S1: taps -> sync1.
//   - S2: sync1 -> sync2.
//   - S3: filter; hit = f[0] & ~prev_f0, where prev_f0 is the registered f[0] of the previous cycle.
//   - S4: encode.
//   - S5: write into the output buffer.
// - Encode:
//   - out_fine = index of the first 0 in f, scanning up from f[0].
//   - If f is all ones, out_fine = N and out_sat = 1; otherwise out_sat = 0.
//   - A hit implies f[0] = 1, so out_fine >= 1.
// - Latency: a hit captured in S1 at edge T gives out_valid=1 after edge T+4 when the buffer was empty.
//   - This latency is independent of N.
// - Output buffer: 2-entry FIFO.
//   - out_* are driven from the head entry; they are held stable while out_valid && !out_ready.
//   - Push and pop in the same cycle are both honoured, including when full.
//   - Hits are spaced at least 2 cycles apart by construction (the edge detect needs f[0] to fall first),
//     so at most one push per cycle.
// - Full: a hit reaching S5 while 2 entries are held and no pop occurs is dropped; overflow <= 1.
//   - overflow stays 1 until clr_ovf.
//   - If clr_ovf coincides with a new drop, the drop wins (overflow stays 1).
// - A hit while f[0] is already 1 is not a new hit. Continuous-high taps produce exactly one result.
// CONFIGURATION
// - TDC_BUBBLE_FILT_EN defined:
//   - f[i] = majority(t[i-1], t[i], t[i+1]) on sync2, with t[-1]=1 and t[N]=t[N-1].
//   - Isolated single-tap bubbles are removed. Costs no extra latency: S3 stays combinational
//     filter + registered edge detect.
// - TDC_BUBBLE_FILT_EN undefined: f = sync2 unmodified. The first raw 0 terminates the count.
// TESTING
// - Reset: hold rst with taps random -> all outputs 0; after release, taps=0 for 10 cycles -> out_valid never 1.
// - Single hit: taps 0 then 0x...00FF held (N=128) from cycle T
//   - -> one result, out_fine=8, out_sat=0, out_coarse=T's count, out_valid at T+4.
// - Saturation: taps 0 then all ones -> out_fine=128, out_sat=1; holding all ones 20 cycles gives no second result.
// - Bubble: taps 0 then 0x...0FBF (bit 6 = 0)
//   - with TDC_BUBBLE_FILT_EN -> out_fine=12.
//   - without -> out_fine=6.
// - Backpressure/overflow: out_ready=0, three hits 3 cycles apart
//   - -> first two held in order, overflow=1 after third.
//   - out_ready=1 drains exactly 2 results; clr_ovf -> overflow=0.
// - Coarse wrap, COARSE_W=4: hit captured when counter=15, next hit at counter=0
//   - -> out_coarse 15 then 0, no extra results.

Source files
------------

// File: rtl/tdc_tap_decoder.sv
// Thermometer-code TDC tap decoder (optional bubble filter: TDC_BUBBLE_FILT_EN).
// Latency: tap capture to out_valid is 4 clk when the buffer is empty, independent of N.
// Backpressure: 2-entry output buffer; a hit arriving while full without a pop is dropped and sets sticky overflow.
module tdc_tap_decoder #(
  parameter int N        = 128,
  parameter int FINE_W   = 8,
  parameter int COARSE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        taps,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FINE_W-1:0]   out_fine,
  output logic [COARSE_W-1:0] out_coarse,
  output logic                out_sat,
  output logic                overflow,
  input  logic                clr_ovf
);

  typedef struct packed {
    logic [FINE_W-1:0]   fine;
    logic [COARSE_W-1:0] coarse;
    logic                sat;
  } res_t;

  logic [N-1:0]        sync1, sync2, f, f3;
  logic [COARSE_W-1:0] coarse, c1, c2, c3, c4;
  logic                prev_f0, hit3, vld4, sat4;
  logic [FINE_W-1:0]   fine4;
  logic [FINE_W-1:0]   enc_fine;
  logic                enc_sat;

`ifdef TDC_BUBBLE_FILT_EN
  // Edges padded so tap 0 sees a 1 below it and the top tap sees itself above.
  logic [N+1:0] ext;
  always_comb begin
    ext = {sync2[N-1], sync2, 1'b1};
    f   = '0;
    for (int i = 0; i < N; i++) begin
      f[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
  end
`else
  always_comb f = sync2;
`endif

  // Leading-ones count: position of the first 0 scanning up from tap 0.
  always_comb begin
    enc_fine = FINE_W'(N);
    for (int i = N - 1; i >= 0; i--) begin
      if (!f3[i]) enc_fine = FINE_W'(i);
    end
    enc_sat = &f3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coarse  <= '0;
      sync1   <= '0;
      sync2   <= '0;
      c1      <= '0;
      c2      <= '0;
      c3      <= '0;
      c4      <= '0;
      prev_f0 <= 1'b0;
      hit3    <= 1'b0;
      f3      <= '0;
      vld4    <= 1'b0;
      fine4   <= '0;
      sat4    <= 1'b0;
    end else begin
      coarse  <= coarse + 1'b1;
      sync1   <= taps;
      c1      <= coarse;
      sync2   <= sync1;
      c2      <= c1;
      prev_f0 <= f[0];
      hit3    <= f[0] & ~prev_f0;
      f3      <= f;
      c3      <= c2;
      vld4    <= hit3;
      fine4   <= enc_fine;
      sat4    <= enc_sat;
      c4      <= c3;
    end
  end

  res_t       mem [2];
  res_t       head;
  logic       wr_ptr, rd_ptr;
  logic [1:0] cnt;
  logic       pop, push, full, drop;

  assign out_valid  = (cnt != 2'd0);
  assign head       = mem[rd_ptr];
  assign out_fine   = head.fine;
  assign out_coarse = head.coarse;
  assign out_sat    = head.sat;
  assign full       = (cnt == 2'd2);
  assign pop        = out_valid & out_ready;
  // When full, a simultaneous pop frees the head slot, which is the one written.
  assign push       = vld4 & (~full | pop);
  assign drop       = vld4 & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      cnt      <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (push) mem[wr_ptr] <= '{fine: fine4, coarse: c4, sat: sat4};
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      cnt    <= cnt + 2'(push) - 2'(pop);
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule
